// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared types and constants for the proc_controller slice
package proc_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 10;
    localparam int DATA_W  = 4;

    // Values 0-7 are the architectural opcodes (ir[9:6] when ir[9]=0).
    // BZ and JMP are encoded by ir[9:8] and get codes outside that range.
    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_ADDI = 4'd3,
        OP_SUBI = 4'd4,
        OP_LDI  = 4'd5,
        OP_MOV  = 4'd6,
        OP_HALT = 4'd7,
        OP_BZ   = 4'd8,
        OP_JMP  = 4'd9
    } op_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_IMM = 2'b01;
    localparam logic [1:0] WB_REG = 2'b10;

    // Only arithmetic ops refresh the zero flag.
    function automatic logic op_sets_z(input op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI) || (op == OP_SUBI);
    endfunction

endpackage

// File: rtl/proc_decode.sv
// rtl/proc_decode.sv - combinational instruction field decoder
// Ports: ir_i (instruction word) -> op_o (op class), rd_o, rs_o, imm_o, target_o
module proc_decode
    import proc_pkg::*;
(
    input  logic [INSTR_W-1:0] ir_i,
    output op_e                op_o,
    output logic [1:0]         rd_o,
    output logic [1:0]         rs_o,
    output logic [DATA_W-1:0]  imm_o,
    output logic [PC_W-1:0]    target_o
);

    always_comb begin
        rd_o     = ir_i[5:4];
        rs_o     = ir_i[3:2];
        imm_o    = ir_i[3:0];
        target_o = ir_i[7:0];
        case (ir_i[9:8])
            2'b11:   op_o = OP_JMP;
            2'b10:   op_o = OP_BZ;
            // ir[9]=0 here, so the 4-bit field is always one of codes 0-7
            default: op_o = op_e'(ir_i[9:6]);
        endcase
    end

endmodule

// File: rtl/proc_controller.sv
// rtl/proc_controller.sv - multi-cycle fetch/decode/exec/writeback controller
// Ports: clk, reset (async, active-high); imem_req/imem_addr/imem_ack/imem_rdata
// instruction fetch; rf_raddr_a/rf_raddr_b/rf_waddr/rf_we register file;
// alu_sub/alu_b_imm/imm/wb_sel datapath controls; alu_zero flag input;
// halted, pc status. Optional macro INSTRET_EN adds instret (16-bit retire count).
module proc_controller
    import proc_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [1:0]         rf_raddr_a,
    output logic [1:0]         rf_raddr_b,
    output logic [1:0]         rf_waddr,
    output logic               rf_we,
    output logic               alu_sub,
    output logic               alu_b_imm,
    output logic [DATA_W-1:0]  imm,
    output logic [1:0]         wb_sel,
    input  logic               alu_zero,
    output logic               halted,
    output logic [PC_W-1:0]    pc
`ifdef INSTRET_EN
    ,
    output logic [15:0]        instret
`endif
);

    state_e               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic                 z_q, z_d;

    op_e                  op;
    logic [1:0]           rd, rs;
    logic [PC_W-1:0]      target;
    logic                 alu_phase;

    proc_decode u_decode (
        .ir_i     (ir_q),
        .op_o     (op),
        .rd_o     (rd),
        .rs_o     (rs),
        .imm_o    (imm),
        .target_o (target)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        z_d     = z_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (op)
                    OP_JMP: begin
                        pc_d    = target;
                        state_d = ST_FETCH;
                    end
                    OP_BZ: begin
                        pc_d    = z_q ? target : pc_q + 8'd1;
                        state_d = ST_FETCH;
                    end
                    OP_NOP: begin
                        pc_d    = pc_q + 8'd1;
                        state_d = ST_FETCH;
                    end
                    OP_HALT: state_d = ST_HALT;
                    default: state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: state_d = ST_WB;
            ST_WB: begin
                pc_d    = pc_q + 8'd1;
                state_d = ST_FETCH;
                if (op_sets_z(op)) begin
                    z_d = alu_zero;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ir_q <= '0;
        else       ir_q <= ir_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) z_q <= 1'b0;
        else       z_q <= z_d;
    end

`ifdef INSTRET_EN
    logic        retire;
    logic [15:0] instret_q;

    // NOP/JMP/BZ retire in DECODE, HALT on entry, everything else in WB.
    assign retire = (state_q == ST_WB) ||
                    ((state_q == ST_DECODE) &&
                     ((op == OP_NOP) || (op == OP_JMP) || (op == OP_BZ) || (op == OP_HALT)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       instret_q <= 16'h0000;
        else if (retire) instret_q <= instret_q + 16'd1;
    end

    assign instret = instret_q;
`endif

    // Datapath controls are valid in EXEC and held through WB.
    assign alu_phase  = (state_q == ST_EXEC) || (state_q == ST_WB);
    assign alu_sub    = alu_phase && ((op == OP_SUB) || (op == OP_SUBI));
    assign alu_b_imm  = alu_phase && ((op == OP_ADDI) || (op == OP_SUBI));
    assign wb_sel     = !alu_phase     ? WB_ALU :
                        (op == OP_LDI) ? WB_IMM :
                        (op == OP_MOV) ? WB_REG : WB_ALU;

    assign imem_req   = (state_q == ST_FETCH);
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign rf_raddr_a = rd;
    assign rf_raddr_b = rs;
    assign rf_waddr   = rd;
    assign rf_we      = (state_q == ST_WB);
    assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_proc_controller.sv
// tb/tb_proc_controller.sv - directed table-driven bench for proc_controller
module tb_proc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [9:0] imem_rdata;
    logic [1:0] rf_raddr_a, rf_raddr_b, rf_waddr;
    logic       rf_we, alu_sub, alu_b_imm, alu_zero, halted;
    logic [3:0] imm;
    logic [1:0] wb_sel;
    logic [7:0] pc;
`ifdef INSTRET_EN
    logic [15:0] instret;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    proc_controller #(.RESET_PC(8'h00)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .rf_waddr   (rf_waddr),
        .rf_we      (rf_we),
        .alu_sub    (alu_sub),
        .alu_b_imm  (alu_b_imm),
        .imm        (imm),
        .wb_sel     (wb_sel),
        .alu_zero   (alu_zero),
        .halted     (halted),
        .pc         (pc)
`ifdef INSTRET_EN
        ,
        .instret    (instret)
`endif
    );

    typedef struct {
        logic [9:0] instr;
        logic       zero;
        int         wait_n;
        int         cycles;
        int         we;
        logic [7:0] pc;
        logic       sub;
        logic       bimm;
        logic [1:0] wbsel;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [3:0] immv;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Entered at a negedge with the DUT in FETCH; returns at the negedge
    // where the DUT is back in FETCH (or HALT).
    task automatic run_instr(input vec_t v, input logic [3:0] prev_imm, input string tag);
        int   n;
        int   we_n;
        logic done;
        for (int i = 0; i < v.wait_n; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = 10'h155;
            @(negedge clk);
            check({tag, " wait_req"}, imem_req, 1'b1);
            check({tag, " wait_we"}, rf_we, 1'b0);
            check({tag, " wait_ir"}, imm, prev_imm);
        end
        imem_ack   = 1'b1;
        imem_rdata = v.instr;
        alu_zero   = v.zero;
        n    = 0;
        we_n = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            // ack stays high with a HALT word outside FETCH; it must be ignored
            imem_rdata = 10'h1C0;
            if (v.we != 0 && n == 2) begin
                check({tag, " exec_sub"}, alu_sub, v.sub);
                check({tag, " exec_bimm"}, alu_b_imm, v.bimm);
                check({tag, " exec_wbsel"}, wb_sel, v.wbsel);
            end
            if (rf_we) begin
                we_n++;
                check({tag, " wb_sub"}, alu_sub, v.sub);
                check({tag, " wb_bimm"}, alu_b_imm, v.bimm);
                check({tag, " wb_sel"}, wb_sel, v.wbsel);
                check({tag, " raddr_a"}, rf_raddr_a, v.rd);
                check({tag, " waddr"}, rf_waddr, v.rd);
                check({tag, " raddr_b"}, rf_raddr_b, v.rs);
                check({tag, " imm"}, imm, v.immv);
            end
            if (imem_req || halted) done = 1'b1;
        end
        imem_ack = 1'b0;
        check({tag, " done"}, done, 1'b1);
        check({tag, " cycles"}, n, v.cycles);
        check({tag, " we_pulses"}, we_n, v.we);
        check({tag, " pc"}, pc, v.pc);
        check({tag, " imem_addr"}, imem_addr, v.pc);
    endtask

    initial begin
        vec_t nop_v, add_v, halt_v, ldi_v, jmp_v;
        int   n;

        //               instr  z  wt cy we pc     sub bim wb     rd    rs    imm
        vecs[0]  = '{10'h143, 0, 0, 4, 1, 8'h01, 0, 0, 2'b01, 2'd0, 2'd0, 4'h3}; // LDI r0,3
        vecs[1]  = '{10'h0C2, 0, 0, 4, 1, 8'h02, 0, 1, 2'b00, 2'd0, 2'd0, 4'h2}; // ADDI r0,2
        vecs[2]  = '{10'h094, 1, 0, 4, 1, 8'h03, 1, 0, 2'b00, 2'd1, 2'd1, 4'h4}; // SUB r1,r1 z=1
        vecs[3]  = '{10'h240, 0, 0, 2, 0, 8'h40, 0, 0, 2'b00, 2'd0, 2'd0, 4'h0}; // BZ 40 taken
        vecs[4]  = '{10'h1AC, 0, 0, 4, 1, 8'h41, 0, 0, 2'b10, 2'd2, 2'd3, 4'hC}; // MOV r2,r3
        vecs[5]  = '{10'h280, 0, 0, 2, 0, 8'h80, 0, 0, 2'b00, 2'd0, 2'd0, 4'h0}; // BZ 80 (z kept)
        vecs[6]  = '{10'h131, 0, 0, 4, 1, 8'h81, 1, 1, 2'b00, 2'd3, 2'd0, 4'h1}; // SUBI r3,1 z=0
        vecs[7]  = '{10'h210, 1, 0, 2, 0, 8'h82, 0, 0, 2'b00, 2'd0, 2'd0, 4'h0}; // BZ 10 not taken
        vecs[8]  = '{10'h058, 0, 5, 4, 1, 8'h83, 0, 0, 2'b00, 2'd1, 2'd2, 4'h8}; // ADD r1,r2, 5 waits
        vecs[9]  = '{10'h000, 0, 0, 2, 0, 8'h84, 0, 0, 2'b00, 2'd0, 2'd0, 4'h0}; // NOP
        vecs[10] = '{10'h3FF, 0, 0, 2, 0, 8'hFF, 0, 0, 2'b00, 2'd0, 2'd0, 4'h0}; // JMP FF
        vecs[11] = '{10'h000, 0, 0, 2, 0, 8'h00, 0, 0, 2'b00, 2'd0, 2'd0, 4'h0}; // NOP wraps
        vecs[12] = '{10'h300, 0, 0, 2, 0, 8'h00, 0, 0, 2'b00, 2'd0, 2'd0, 4'h0}; // JMP self
        vecs[13] = '{10'h300, 0, 0, 2, 0, 8'h00, 0, 0, 2'b00, 2'd0, 2'd0, 4'h0}; // JMP self again

        nop_v  = '{10'h000, 0, 0, 2, 0, 8'h01, 0, 0, 2'b00, 2'd0, 2'd0, 4'h0};
        add_v  = '{10'h058, 0, 0, 4, 1, 8'h02, 0, 0, 2'b00, 2'd1, 2'd2, 4'h8};
        halt_v = '{10'h1C0, 0, 0, 2, 0, 8'h00, 0, 0, 2'b00, 2'd0, 2'd0, 4'h0};

        imem_ack   = 1'b0;
        imem_rdata = 10'h000;
        alu_zero   = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        check("rst pc", pc, 8'h00);
        check("rst rf_we", rf_we, 1'b0);
        check("rst halted", halted, 1'b0);
        check("rst imm", imm, 4'h0);
        @(negedge clk);
        reset = 1'b0;
        check("rel imem_req", imem_req, 1'b1);
        check("rel imem_addr", imem_addr, 8'h00);

        for (int i = 0; i < 14; i++) begin
            logic [9:0] prev;
            prev = (i == 0) ? 10'h000 : vecs[i-1].instr;
            run_instr(vecs[i], prev[3:0], $sformatf("vec%0d", i));
        end

        // HALT is terminal and ignores ack
        run_instr(halt_v, 4'h0, "halt");
        imem_ack   = 1'b1;
        imem_rdata = 10'h000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("halt halted", halted, 1'b1);
            check("halt imem_req", imem_req, 1'b0);
            check("halt rf_we", rf_we, 1'b0);
        end
        check("halt pc", pc, 8'h00);
        imem_ack = 1'b0;

        // Reset in the middle of WB of ADD aborts the write and pc update
        do_reset();
        run_instr(nop_v, 4'h0, "pre_add");
        imem_ack   = 1'b1;
        imem_rdata = add_v.instr;
        n = 0;
        while (!rf_we && n < 10) begin
            @(negedge clk);
            n++;
        end
        imem_ack = 1'b0;
        check("midwb reach_wb", n, 3);
        check("midwb pc_before", pc, 8'h01);
        #1 reset = 1'b1;
        #1;
        check("midwb rf_we", rf_we, 1'b0);
        check("midwb pc", pc, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midwb pc_after", pc, 8'h00);
        check("midwb req_after", imem_req, 1'b1);
        check("midwb rf_we_after", rf_we, 1'b0);

        // Reset while waiting in FETCH
        run_instr(nop_v, 4'h0, "pre_fetch_rst");
        imem_ack = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("midfetch pc", pc, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midfetch req", imem_req, 1'b1);

`ifdef INSTRET_EN
        do_reset();
        check("instret reset", instret, 16'd0);
        ldi_v = vecs[0];
        run_instr(ldi_v, 4'h0, "ir_ldi");
        nop_v.pc = 8'h02;
        run_instr(nop_v, 4'h3, "ir_nop");
        jmp_v = '{10'h305, 0, 0, 2, 0, 8'h05, 0, 0, 2'b00, 2'd0, 2'd0, 4'h0};
        run_instr(jmp_v, 4'h0, "ir_jmp");
        halt_v.pc = 8'h05;
        run_instr(halt_v, 4'h5, "ir_halt");
        @(negedge clk);
        check("instret count", instret, 16'd4);
`else
        ldi_v = vecs[0];
        jmp_v = vecs[12];
        check("ldi_v instr", {22'd0, ldi_v.instr}, 32'h143);
        check("jmp_v instr", {22'd0, jmp_v.instr}, 32'h300);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/proc_controller.md
PROC_CONTROLLER -- requirements
Module: proc_controller

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00: PC value loaded on reset.
REQ-002 SHALL have ports clk (input, 1, clock) and reset (input, 1, reset); reset is asynchronous, active-high; clock clk.
REQ-003 SHALL have imem_req (output, 1): fetch request; imem_addr (output, 8): equals pc.
REQ-004 SHALL have imem_ack (input, 1): fetch done; imem_rdata (input, 10): instruction word, valid when imem_ack=1.
REQ-005 SHALL have rf_raddr_a (output, 2) = rd; rf_raddr_b (output, 2) = rs; rf_waddr (output, 2) = rd; rf_we (output, 1).
REQ-006 SHALL have alu_sub (output, 1): ALU subtract control; alu_b_imm (output, 1): ALU operand B mux select (0 = reg B, 1 = imm).
REQ-007 SHALL have imm (output, 4) = ir[3:0]; wb_sel (output, 2): 00 ALU, 01 imm, 10 reg B.
REQ-008 SHALL have alu_zero (input, 1): ALU result == 0; halted (output, 1); pc (output, 8).

Function
REQ-009 SHALL decode 10-bit ir as follows: ir[9:8]=11 -> JMP ir[7:0]; ir[9:8]=10 -> BZ ir[7:0]; otherwise opcode = ir[9:6], rd = ir[5:4], rs = ir[3:2].
REQ-010 SHALL use opcodes 0000 NOP, 0001 ADD rd+=rs, 0010 SUB rd-=rs, 0011 ADDI rd+=imm, 0100 SUBI rd-=imm, 0101 LDI rd=imm, 0110 MOV rd=rs, 0111 HALT.
REQ-011 SHALL use FSM states FETCH, DECODE, EXEC, WB, HALT.
REQ-012 FETCH: SHALL assert imem_req and hold it until imem_ack; on ack, load ir from imem_rdata and go to DECODE.
REQ-013 DECODE transitions:
- JMP: pc <= target, go to FETCH.
- BZ: pc <= target if z=1, else pc+1; go to FETCH.
- NOP: pc+1, go to FETCH.
- HALT: go to HALT with pc unchanged.
- All others: go to EXEC.
REQ-014 EXEC: SHALL drive alu_sub (1 for SUB/SUBI), alu_b_imm (1 for ADDI/SUBI) and wb_sel; go to WB.
REQ-015 WB: SHALL assert rf_we for exactly one cycle, increment pc and go to FETCH; controls from REQ-014 held stable during WB.
REQ-016 Z flag register: SHALL load alu_zero in WB of ADD/SUB/ADDI/SUBI only; LDI/MOV/NOP/jumps leave it unchanged.
REQ-017 Latency with same-cycle ack: ALU/LDI/MOV 4 cycles, NOP/JMP/BZ 2 cycles, plus each wait cycle for imem_ack.
REQ-018 pc SHALL be 8-bit and wrap 8'hFF+1 -> 8'h00.
REQ-019 imem_ack outside FETCH SHALL be ignored.
REQ-020 rf_we SHALL be 0 in every state except WB.
REQ-021 HALT SHALL be terminal until reset: halted=1, imem_req=0, rf_we=0.
REQ-022 JMP to its own address SHALL loop, fetching every 2 cycles.

Reset
REQ-023 On reset: state FETCH, pc = RESET_PC, ir = 0, z = 0, halted = 0, rf_we = 0; imem_req asserted from first cycle after release.
REQ-024 Reset mid-fetch or mid-WB SHALL abort the instruction with no register write and no pc update.

Configuration
REQ-025 With INSTRET_EN defined: SHALL add output instret (16), reset 0, incremented once per retired instruction (WB, NOP, JMP, BZ, HALT entry), wrapping at 16'hFFFF.
REQ-026 Without INSTRET_EN: SHALL have no instret port and no counter logic.

Structure
REQ-027 proc_pkg SHALL hold the opcode enum, state enum, wb_sel constants, PC_W=8, INSTR_W=10 and DATA_W=4.
REQ-028 SHALL contain one combinational sub-module, proc_decode (ir -> op class, rd, rs, imm, target); pc/ir/z registers use flopr-style async-reset flops.

Verification
REQ-029 Reset, then program LDI r0,3; ADDI r0,2 with ack immediate -> rf_we pulses in cycles 4 and 8; imm=3 with wb_sel=01, then alu_b_imm=1, alu_sub=0.
REQ-030 SUB r1,r1 with alu_zero=1, then BZ 8'h40 -> pc=8'h40 after DECODE; same with alu_zero=0 -> pc = BZ address + 1.
REQ-031 imem_ack held low 5 cycles in FETCH -> imem_req held 6 cycles, ir unchanged until ack, no rf_we.
REQ-032 pc=8'hFF executing NOP -> next imem_addr=8'h00.
REQ-033 HALT -> halted=1, imem_req=0 for 20 cycles; assert reset mid-WB of ADD -> rf_we=0, pc=RESET_PC.
REQ-034 With INSTRET_EN: 3 instructions then HALT -> instret=4.
